// File: rtl/tt_compare_sched.sv
// Tag table with lowest-free allocation and one round-robin-shared masked compare port.
// Lookups only query; releases also invalidate every matching entry at the same edge.

module tt_compare_entry #(
    parameter int VALUE_WIDTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_we,
    input  logic [VALUE_WIDTH-1:0] i_wdata,
    input  logic                   i_valid,
    input  logic [VALUE_WIDTH-1:0] i_cmp_value,
    input  logic [VALUE_WIDTH-1:0] i_cmp_mask,
    output logic                   o_match
);
    logic [VALUE_WIDTH-1:0] data_q, data_d;

    always_comb data_d = i_we ? i_wdata : data_q;

    // Entry data is deliberately not reset; the valid bit qualifies it.
    always_ff @(posedge i_clk) data_q <= data_d;

    assign o_match = i_valid & ~|((i_cmp_value ^ data_q) & ~i_cmp_mask);
endmodule

module tt_compare_sched #(
    parameter int VALUE_WIDTH = 32,
    parameter int ENTRIES     = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_flush,
    input  logic                          i_alloc_valid,
    input  logic [VALUE_WIDTH-1:0]        i_alloc_value,
    output logic                          o_alloc_ready,
    output logic [$clog2(ENTRIES)-1:0]    o_alloc_id,
    input  logic                          i_lkp_valid,
    input  logic [VALUE_WIDTH-1:0]        i_lkp_value,
    input  logic [VALUE_WIDTH-1:0]        i_lkp_mask,
    output logic                          o_lkp_ready,
    input  logic                          i_rel_valid,
    input  logic [VALUE_WIDTH-1:0]        i_rel_value,
    input  logic [VALUE_WIDTH-1:0]        i_rel_mask,
    output logic                          o_rel_ready,
    output logic                          o_rsp_valid,
    output logic                          o_rsp_src,
    output logic                          o_rsp_hit,
    output logic                          o_rsp_multi,
    output logic [ENTRIES-1:0]            o_rsp_match,
    output logic [ENTRIES-1:0]            o_valid_entries,
    output logic [$clog2(ENTRIES+1)-1:0]  o_count
);
    localparam int ID_WIDTH  = $clog2(ENTRIES);
    localparam int CNT_WIDTH = $clog2(ENTRIES+1);

    typedef enum logic {SRC_LKP = 1'b0, SRC_REL = 1'b1} src_e;

    typedef struct packed {
        logic               src;
        logic               hit;
        logic               multi;
        logic [ENTRIES-1:0] match;
    } rsp_t;

    logic [ENTRIES-1:0]     valid_q, valid_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    src_e                   ptr_q, ptr_d;
    logic                   rsp_valid_q, rsp_valid_d;
    rsp_t                   rsp_q, rsp_d;

    logic                   grant_lkp, grant_rel, alloc_fire;
    logic [ID_WIDTH-1:0]    alloc_id;
    logic [ENTRIES-1:0]     alloc_onehot, match, rel_clear;
    logic [VALUE_WIDTH-1:0] cmp_value, cmp_mask;

    // Lowest free entry, taken from start-of-cycle valid bits only.
    always_comb begin
        alloc_id = '0;
        for (int e = ENTRIES-1; e >= 0; e--) begin
            if (!valid_q[e]) alloc_id = ID_WIDTH'(e);
        end
    end

    assign o_alloc_ready = ~(&valid_q) & ~i_flush;
    assign o_alloc_id    = alloc_id;
    assign alloc_fire    = i_alloc_valid & o_alloc_ready;

    always_comb begin
        alloc_onehot = '0;
        alloc_onehot[alloc_id] = alloc_fire;
    end

    assign grant_lkp   = ~i_flush & i_lkp_valid & (~i_rel_valid | (ptr_q == SRC_LKP));
    assign grant_rel   = ~i_flush & i_rel_valid & (~i_lkp_valid | (ptr_q == SRC_REL));
    assign o_lkp_ready = grant_lkp;
    assign o_rel_ready = grant_rel;

    assign cmp_value = grant_rel ? i_rel_value : i_lkp_value;
    assign cmp_mask  = grant_rel ? i_rel_mask  : i_lkp_mask;

    for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
        tt_compare_entry #(.VALUE_WIDTH(VALUE_WIDTH)) u_entry (
            .i_clk       (i_clk),
            .i_we        (alloc_onehot[e]),
            .i_wdata     (i_alloc_value),
            .i_valid     (valid_q[e]),
            .i_cmp_value (cmp_value),
            .i_cmp_mask  (cmp_mask),
            .o_match     (match[e])
        );
    end

    assign rel_clear = grant_rel ? match : '0;

    always_comb begin
        ptr_d = ptr_q;
        if (grant_lkp) ptr_d = SRC_REL;
        if (grant_rel) ptr_d = SRC_LKP;

        valid_d = i_flush ? '0 : ((valid_q & ~rel_clear) | alloc_onehot);

        count_d = '0;
        for (int e = 0; e < ENTRIES; e++) count_d = count_d + CNT_WIDTH'(valid_d[e]);

        rsp_valid_d = grant_lkp | grant_rel;
        rsp_d       = rsp_q;
        if (rsp_valid_d) begin
            rsp_d.src   = grant_rel;
            rsp_d.hit   = |match;
            rsp_d.multi = |(match & (match - ENTRIES'(1)));
            rsp_d.match = match;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_q     <= '0;
            count_q     <= '0;
            ptr_q       <= SRC_LKP;
            rsp_valid_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            count_q     <= count_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Response payload holds its last value between pulses.
    always_ff @(posedge i_clk) rsp_q <= rsp_d;

    assign o_rsp_valid     = rsp_valid_q;
    assign o_rsp_src       = rsp_q.src;
    assign o_rsp_hit       = rsp_q.hit;
    assign o_rsp_multi     = rsp_q.multi;
    assign o_rsp_match     = rsp_q.match;
    assign o_valid_entries = valid_q;
    assign o_count         = count_q;
endmodule

// File: tb/tb_tt_compare_sched.sv
// Directed bench for tt_compare_sched; expected responses go through a scoreboard queue
// popped by an independent negedge monitor.

module tb_tt_compare_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        alloc_valid;
    logic [31:0] alloc_value;
    logic        alloc_ready;
    logic [1:0]  alloc_id;
    logic        lkp_valid, rel_valid, lkp_ready, rel_ready;
    logic [31:0] lkp_value, lkp_mask, rel_value, rel_mask;
    logic        rsp_valid, rsp_src, rsp_hit, rsp_multi;
    logic [3:0]  rsp_match, valid_entries;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       src;
        logic       hit;
        logic       multi;
        logic [3:0] match;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    tt_compare_sched dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush),
        .i_alloc_valid(alloc_valid), .i_alloc_value(alloc_value),
        .o_alloc_ready(alloc_ready), .o_alloc_id(alloc_id),
        .i_lkp_valid(lkp_valid), .i_lkp_value(lkp_value), .i_lkp_mask(lkp_mask),
        .o_lkp_ready(lkp_ready),
        .i_rel_valid(rel_valid), .i_rel_value(rel_value), .i_rel_mask(rel_mask),
        .o_rel_ready(rel_ready),
        .o_rsp_valid(rsp_valid), .o_rsp_src(rsp_src), .o_rsp_hit(rsp_hit),
        .o_rsp_multi(rsp_multi), .o_rsp_match(rsp_match),
        .o_valid_entries(valid_entries), .o_count(count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic src, input logic hit, input logic multi, input logic [3:0] m);
        exp_t e;
        e.src = src; e.hit = hit; e.multi = multi; e.match = m;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; alloc_valid = 0; lkp_valid = 0; rel_valid = 0;
        alloc_value = '0; lkp_value = '0; lkp_mask = '0; rel_value = '0; rel_mask = '0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_src",   32'(rsp_src),   32'(e.src));
                chk("rsp_hit",   32'(rsp_hit),   32'(e.hit));
                chk("rsp_multi", 32'(rsp_multi), 32'(e.multi));
                chk("rsp_match", 32'(rsp_match), 32'(e.match));
            end
        end
    end

    initial begin
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        #1;
        chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        chk("rst_alloc_id",    32'(alloc_id),    32'd0);
        chk("rst_valid",       32'(valid_entries), 32'd0);
        chk("rst_count",       32'(count),       32'd0);
        chk("rst_rsp_valid",   32'(rsp_valid),   32'd0);

        // Arbitration from reset on an empty table: lkp, rel, lkp, rel
        lkp_valid = 1; rel_valid = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("arb_lkp_ready", 32'(lkp_ready), 32'(i % 2 == 0));
            chk("arb_rel_ready", 32'(rel_ready), 32'(i % 2 == 1));
            push(1'(i % 2), 1'b0, 1'b0, 4'b0000);
            step();
        end
        idle();

        // Fill and over-fill
        for (int i = 0; i < 4; i++) begin
            alloc_valid = 1; alloc_value = 32'h10 * (i + 1);
            #1;
            chk("fill_ready", 32'(alloc_ready), 32'd1);
            chk("fill_id",    32'(alloc_id),    32'(i));
            step();
        end
        alloc_valid = 1; alloc_value = 32'h50;
        #1;
        chk("full_ready", 32'(alloc_ready), 32'd0);
        step();
        idle();
        chk("full_valid", 32'(valid_entries), 32'hf);
        chk("full_count", 32'(count), 32'd4);

        // Lookup single hit, then confirm 0x50 was never written
        lkp_valid = 1; lkp_value = 32'h20;
        #1 chk("lkp_ready", 32'(lkp_ready), 32'd1);
        push(1'b0, 1'b1, 1'b0, 4'b0010);
        step();
        lkp_value = 32'h50;
        push(1'b0, 1'b0, 1'b0, 4'b0000);
        chk("lkp_valid_kept", 32'(valid_entries), 32'hf);
        step();
        idle();
        chk("lkp_valid_kept2", 32'(valid_entries), 32'hf);

        // Masked release: 0x10/0x20/0x30 match with bits [5:4] ignored
        rel_valid = 1; rel_value = 32'h0; rel_mask = 32'h30;
        push(1'b1, 1'b1, 1'b1, 4'b0111);
        step();
        idle();
        chk("mrel_valid", 32'(valid_entries), 32'h8);
        chk("mrel_count", 32'(count), 32'd1);

        rel_valid = 1; rel_value = 32'h40;
        push(1'b1, 1'b1, 1'b0, 4'b1000);
        step();
        idle();
        chk("rel40_valid", 32'(valid_entries), 32'h0);
        alloc_valid = 1; alloc_value = 32'h10;
        #1 chk("realloc_id", 32'(alloc_id), 32'd0);
        step();
        idle();
        chk("realloc_valid", 32'(valid_entries), 32'h1);

        // Same-cycle allocate and release: freed entry 0 not reused
        alloc_valid = 1; alloc_value = 32'h99;
        rel_valid = 1; rel_value = 32'h10;
        #1 chk("same_alloc_id", 32'(alloc_id), 32'd1);
        push(1'b1, 1'b1, 1'b0, 4'b0001);
        step();
        idle();
        chk("same_valid", 32'(valid_entries), 32'h2);
        chk("same_count", 32'(count), 32'd1);

        // New entry invisible to a compare in its allocation cycle
        alloc_valid = 1; alloc_value = 32'h77;
        lkp_valid = 1; lkp_value = 32'h77;
        #1 chk("vis_alloc_id", 32'(alloc_id), 32'd0);
        push(1'b0, 1'b0, 1'b0, 4'b0000);
        step();
        alloc_valid = 0;
        push(1'b0, 1'b1, 1'b0, 4'b0001);
        step();
        idle();
        chk("vis_valid", 32'(valid_entries), 32'h3);
        chk("vis_count", 32'(count), 32'd2);

        // Flush overlapping a registered response
        lkp_valid = 1; lkp_value = 32'h99;
        push(1'b0, 1'b1, 1'b0, 4'b0010);
        step();
        flush = 1; rel_valid = 1; alloc_valid = 1; alloc_value = 32'h5;
        #1;
        chk("flush_lkp_ready",   32'(lkp_ready),   32'd0);
        chk("flush_rel_ready",   32'(rel_ready),   32'd0);
        chk("flush_alloc_ready", 32'(alloc_ready), 32'd0);
        step();
        idle();
        chk("flush_valid",     32'(valid_entries), 32'h0);
        chk("flush_count",     32'(count),         32'd0);
        chk("flush_rsp_valid", 32'(rsp_valid),     32'd0);

        // Reset asserted with a response in flight
        alloc_valid = 1; alloc_value = 32'h5;
        step();
        idle();
        lkp_valid = 1; lkp_value = 32'h5;
        step();
        idle();
        rst_n = 0;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid),     32'd0);
        chk("mid_rst_valid",     32'(valid_entries), 32'h0);
        chk("mid_rst_count",     32'(count),         32'd0);
        step();
        rst_n = 1;
        #1 chk("mid_rst_alloc_id", 32'(alloc_id), 32'd0);
        repeat (3) step();
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tt_compare_sched.md
# tt_compare_sched

Tag-table controller that owns a small associative table of ENTRIES values and shares a single masked-compare port between two requesters: lookup (query only) and release (query and invalidate matches). Allocation fills the lowest free entry. The block sits beside the vector-unit issue logic and tracks in-flight tags, e.g. outstanding load IDs. All compare results are registered and returned one cycle after acceptance.

## Interface
- VALUE_WIDTH, 32: width of stored and compared values.
- ENTRIES, 4: number of table entries; must be at least 2.
- ID_WIDTH, $clog2(ENTRIES): derived localparam, entry index width.
- CNT_WIDTH, $clog2(ENTRIES+1): derived localparam, occupancy width.

- i_clk  in  1  clock; all state is on the rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_flush  in  1  invalidates every entry at the edge.
- i_alloc_valid  in  1  allocation request.
- i_alloc_value  in  VALUE_WIDTH  value to store.
- o_alloc_ready  out  1  a free entry exists and no flush is active.
- o_alloc_id  out  ID_WIDTH  index that the current allocation will take (lowest free entry).
- i_lkp_valid / i_rel_valid  in  1  lookup / release request.
- i_lkp_value / i_rel_value  in  VALUE_WIDTH  compare value.
- i_lkp_mask / i_rel_mask  in  VALUE_WIDTH  1 = bit ignored in compare.
- o_lkp_ready / o_rel_ready  out  1  grant; the request is accepted on valid&ready.
- o_rsp_valid  out  1  one-cycle response pulse.
- o_rsp_src  out  1  0 = lookup, 1 = release.
- o_rsp_hit  out  1  at least one entry matched.
- o_rsp_multi  out  1  more than one entry matched.
- o_rsp_match  out  ENTRIES  per-entry match vector.
- o_valid_entries  out  ENTRIES  current valid bits.
- o_count  out  CNT_WIDTH  number of valid entries.

## Operation
- **Compare rule.** match[e] = valid[e] & ~|((value ^ entry[e]) & ~mask). The compare is evaluated against the valid bits and entries as they stand at the start of the cycle.
- **Arbiter.** Round-robin, one compare per cycle.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester the priority pointer names is granted. The pointer then moves to the other requester.
  - The pointer is unchanged when no request is accepted.
  - Reset value of the pointer: lookup.
  - Ready may depend combinationally on the valids.
  - A requester holds valid and its operands stable until accepted.
- **Release.** An accepted release clears valid[e] for every matching e at the same edge. Entry data is left unchanged.
- **Allocate.** An accepted allocation writes the entry at o_alloc_id and sets its valid bit.
  - The free entry is chosen from start-of-cycle valid bits. An entry freed by a release in the same cycle cannot be reused until the next cycle.
  - A new entry is not visible to a compare in its allocation cycle.
- **Flush.** i_flush has priority over everything else.
  - In a flush cycle, o_alloc_ready, o_lkp_ready and o_rel_ready are 0.
  - All valid bits clear at the edge.
  - No response is generated for the flush cycle.
  - A response already registered from the previous cycle is still presented.
- **Occupancy.** o_count = popcount(valid), registered alongside the valid bits.
- **Response registers.** Only o_rsp_valid is reset. The other o_rsp_* hold their last value when o_rsp_valid = 0.
- **Reset values.**
  - valid = 0, o_count = 0, o_rsp_valid = 0, pointer = lookup.
  - Entry data is not reset.
  - o_alloc_ready = 1 and o_alloc_id = 0 after reset (combinational).

## Timing
- **Compare latency.** 1 cycle: a request accepted in cycle N responds in cycle N+1 with o_rsp_valid = 1.
- **Throughput.** One compare per cycle; the two requesters are served back-to-back with no bubbles.
- **No response backpressure.** The consumer must accept every pulse.
- **Release effect.** valid is low in cycle N+1, coincident with the response.
- **Simultaneous accepted events in one cycle.** Allocate, compare and release may all complete in the same cycle.
  - valid_next = (valid & ~release_match) | alloc_onehot.
  - release_match and alloc_onehot are disjoint by construction.
- **Full table.** o_alloc_ready = 0 and i_alloc_valid is ignored; lookups and releases continue to be served.
- **Empty table.** Every compare returns hit = 0, match = 0.
- **Reset asserted mid-operation.** Clears state immediately. No response is generated for requests in flight.

## Test plan
- **Fill and over-fill.** After reset, allocate 0x10, 0x20, 0x30, 0x40 on consecutive cycles, then allocate 0x50.
  - Required: ids 0,1,2,3; o_count = 4; o_alloc_ready = 0 on the fifth request; the fifth value is not written.
- **Lookup, single hit.** With the table full, lookup value 0x20, mask 0.
  - Required: next cycle rsp_valid = 1, src = 0, match = 4'b0010, hit = 1, multi = 0; valid is unchanged.
- **Masked release.** Release value 0x00, mask 0x30.
  - Required: match = 4'b0111, multi = 1; valid = 4'b1000 in the response cycle; o_count = 1.
- **Arbitration.** Lookup and release both valid for 4 cycles, starting from reset.
  - Required: grants are lkp, rel, lkp, rel; responses arrive on 4 consecutive cycles with src alternating 0,1,0,1.
- **Same-cycle allocate and release.** valid = 4'b0001 (entry0 = 0x10). In one cycle, allocate 0x99 and release 0x10.
  - Required: allocation takes id 1 (not 0); valid = 4'b0010 next cycle; the release response has match = 4'b0001.
- **Flush overlapping a response.** Accept a lookup in cycle N and assert i_flush in cycle N+1.
  - Required: the response for cycle N is presented in N+1; all readies are 0 in N+1; valid = 0 and o_count = 0 in N+2; o_rsp_valid = 0 in N+2.
